// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter sharing one memory/MMIO slave port.
// Latency: grant 1 cycle after valid is sampled; ready pulse the cycle after s_ready
//          is sampled (2 cycles minimum, 3 cycles per transfer back-to-back).
// Backpressure: requesters hold valid until their ready pulse; the slave stalls by
//               withholding s_ready, bounded by TIMEOUT_CYCLES and then a bus-error reply.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   m0_* / m1_*                 requester ports (valid/addr/wdata/wstrb in, ready/rdata out)
//   s_valid/s_addr/s_wdata/s_wstrb  registered request to the shared slave
//   s_ready/s_rdata             slave completion and read data
//   s_owner                     index of current/last granted requester
//   err_flag/err_addr/err_clear sticky timeout status, faulting address, clear strobe
module mem_bus_arbiter #(
  parameter int unsigned         DATA_W         = 32,
  parameter int unsigned         TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]   ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              m0_valid,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_valid,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              s_valid,
  output logic [31:0]       s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,

  output logic              s_owner,
  output logic              err_flag,
  output logic [31:0]       err_addr,
  input  logic              err_clear
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic              s_valid_q;
  logic [31:0]       s_addr_q;
  logic [DATA_W-1:0] s_wdata_q;
  logic [3:0]        s_wstrb_q;
  logic              s_owner_q;
  logic              last_grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              m0_ready_q;
  logic              m1_ready_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;
  logic              err_flag_q;
  logic [31:0]       err_addr_q;

  // Arbitration and request selection (only consumed in IDLE).
  logic              grant_vld_d;
  logic              grant_d;
  logic [31:0]       req_addr_d;
  logic [DATA_W-1:0] req_wdata_d;
  logic [3:0]        req_wstrb_d;

  // Completion of the transfer in BUSY: slave answer or timeout.
  logic              timeout_d;
  logic              rsp_fire_d;
  logic [DATA_W-1:0] rsp_dat_d;

  always_comb begin
    grant_vld_d = m0_valid | m1_valid;
    // On a tie the requester that did not win last time gets the port;
    // otherwise whichever one is asking (m0 when only m0 is valid).
    if (m0_valid && m1_valid) begin
      grant_d = ~last_grant_q;
    end else begin
      grant_d = m1_valid;
    end
    req_addr_d  = grant_d ? m1_addr  : m0_addr;
    req_wdata_d = grant_d ? m1_wdata : m0_wdata;
    req_wstrb_d = grant_d ? m1_wstrb : m0_wstrb;
  end

  always_comb begin
    // s_ready wins over the timeout if both land in the same cycle.
    timeout_d  = !s_ready && (cnt_q == CNT_LAST);
    rsp_fire_d = s_ready || timeout_d;
    rsp_dat_d  = s_ready ? s_rdata : ERR_DATA;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      s_valid_q    <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_wstrb_q    <= '0;
      s_owner_q    <= 1'b0;
      last_grant_q <= 1'b1;  // makes m0 win the first tie
      cnt_q        <= '0;
      m0_ready_q   <= 1'b0;
      m1_ready_q   <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      err_flag_q   <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      // Ready is a one-cycle pulse: default low, raised only on completion.
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;

      // A timeout in the same cycle overrides this clear further down.
      if (err_clear) begin
        err_flag_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (grant_vld_d) begin
            s_addr_q     <= req_addr_d;
            s_wdata_q    <= req_wdata_d;
            s_wstrb_q    <= req_wstrb_d;
            s_owner_q    <= grant_d;
            last_grant_q <= grant_d;
            cnt_q        <= '0;
            s_valid_q    <= 1'b1;
            state_q      <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (rsp_fire_d) begin
            if (s_owner_q) begin
              m1_rdata_q <= rsp_dat_d;
              m1_ready_q <= 1'b1;
            end else begin
              m0_rdata_q <= rsp_dat_d;
              m0_ready_q <= 1'b1;
            end
            if (timeout_d) begin
              err_flag_q <= 1'b1;
              err_addr_q <= s_addr_q;
            end
            s_valid_q <= 1'b0;
            state_q   <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RESP: begin
          // Ready pulse is visible this cycle; it drops by default above.
          state_q <= ST_IDLE;
        end

        default: begin
          s_valid_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_valid  = s_valid_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wstrb  = s_wstrb_q;
  assign s_owner  = s_owner_q;
  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign err_flag = err_flag_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with TIMEOUT_CYCLES = 8.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Every check is an immediate assertion with hand-computed expected values.
module tb_mem_bus_arbiter;

  localparam int unsigned TMO = 8;

  logic        clk;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        s_owner;
  logic        err_flag;
  logic [31:0] err_addr;
  logic        err_clear;

  int n_chk  = 0;
  int n_fail = 0;

  mem_bus_arbiter #(
    .DATA_W(32),
    .TIMEOUT_CYCLES(TMO),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .s_owner(s_owner), .err_flag(err_flag), .err_addr(err_addr), .err_clear(err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic        exp_owner;
  logic [31:0] exp_m0_rdata, exp_m1_rdata, rd;

  initial begin
    resetn = 1'b1;
    m0_valid = 0; m1_valid = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; m0_wstrb = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0; err_clear = 0;
    #2 resetn = 1'b0;
    #1;
    // ---- reset state ----
    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wdata", s_wdata, 0);
    chk("rst_s_wstrb", s_wstrb, 0);
    chk("rst_m0_ready", m0_ready, 0);
    chk("rst_m1_ready", m1_ready, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_s_owner", s_owner, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_err_addr", err_addr, 0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // ---- single m0 read, slave answers in the first BUSY cycle ----
    m0_valid = 1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0;
    tick();  // edge 0: grant
    chk("rd_s_valid", s_valid, 1);
    chk("rd_s_addr", s_addr, 32'h0000_0010);
    chk("rd_s_owner", s_owner, 0);
    chk("rd_m0_ready_early", m0_ready, 0);
    s_ready = 1; s_rdata = 32'h1234_5678;
    tick();  // edge 1: slave answer sampled
    chk("rd_m0_ready", m0_ready, 1);
    chk("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("rd_m1_ready", m1_ready, 0);
    chk("rd_s_valid_resp", s_valid, 0);
    m0_valid = 0; s_ready = 0;
    tick();
    chk("rd_m0_ready_pulse", m0_ready, 0);
    chk("rd_m0_rdata_hold", m0_rdata, 32'h1234_5678);
    exp_m0_rdata = 32'h1234_5678;
    exp_m1_rdata = 32'h0;

    // ---- both valid, slave always ready: grants alternate ----
    // m0 won last, so the first tie goes to m1.
    m0_valid = 1; m0_addr = 32'hA000_0000;
    m1_valid = 1; m1_addr = 32'hB000_0000;
    s_ready = 1;
    exp_owner = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd = 32'h5A00_0000 + i;
      s_rdata = rd;
      tick();  // grant
      chk("rr_s_owner", s_owner, exp_owner);
      chk("rr_s_addr", s_addr, exp_owner ? 32'hB000_0000 : 32'hA000_0000);
      tick();  // completion
      if (exp_owner) exp_m1_rdata = rd; else exp_m0_rdata = rd;
      chk("rr_m0_ready", m0_ready, exp_owner ? 0 : 1);
      chk("rr_m1_ready", m1_ready, exp_owner ? 1 : 0);
      chk("rr_m0_rdata", m0_rdata, exp_m0_rdata);
      chk("rr_m1_rdata", m1_rdata, exp_m1_rdata);
      tick();  // RESP -> IDLE, s_ready high here must be ignored
      chk("rr_m0_ready_off", m0_ready, 0);
      chk("rr_m1_ready_off", m1_ready, 0);
      chk("rr_s_valid_idle", s_valid, 0);
      exp_owner = ~exp_owner;
    end
    m0_valid = 0; m1_valid = 0; s_ready = 0;

    // ---- m1 write, slave waits 5 cycles ----
    m1_valid = 1; m1_addr = 32'h1000_0000; m1_wstrb = 4'hF; m1_wdata = 32'h0000_0041;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("wr_s_valid", s_valid, 1);
      chk("wr_s_addr", s_addr, 32'h1000_0000);
      chk("wr_s_wdata", s_wdata, 32'h0000_0041);
      chk("wr_s_wstrb", s_wstrb, 4'hF);
      chk("wr_s_owner", s_owner, 1);
      chk("wr_m1_ready_wait", m1_ready, 0);
      tick();
    end
    s_ready = 1; s_rdata = 32'hCAFE_0001;
    tick();
    chk("wr_m1_ready", m1_ready, 1);
    chk("wr_m1_rdata", m1_rdata, 32'hCAFE_0001);
    chk("wr_m0_ready", m0_ready, 0);
    chk("wr_m0_rdata_kept", m0_rdata, exp_m0_rdata);
    chk("wr_s_valid_resp", s_valid, 0);
    m1_valid = 0; s_ready = 0; m1_wstrb = 0;
    tick();
    chk("wr_m1_ready_off", m1_ready, 0);

    // ---- timeout: s_valid high exactly TMO cycles ----
    m0_valid = 1; m0_addr = 32'h3000_0000;
    tick();
    for (int i = 0; i < TMO; i++) begin
      chk("to_s_valid_hi", s_valid, 1);
      chk("to_m0_ready_wait", m0_ready, 0);
      tick();
    end
    chk("to_s_valid_lo", s_valid, 0);
    chk("to_m0_ready", m0_ready, 1);
    chk("to_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("to_err_flag", err_flag, 1);
    chk("to_err_addr", err_addr, 32'h3000_0000);
    m0_valid = 0;
    tick();
    chk("to_m0_ready_off", m0_ready, 0);
    chk("to_err_sticky", err_flag, 1);
    err_clear = 1;
    tick();
    err_clear = 0;
    chk("to_err_cleared", err_flag, 0);

    // second timeout with err_clear on the timeout edge: flag stays set
    m0_valid = 1; m0_addr = 32'h3000_0040;
    tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    err_clear = 1;
    tick();
    err_clear = 0;
    chk("to2_m0_ready", m0_ready, 1);
    chk("to2_err_flag", err_flag, 1);
    chk("to2_err_addr", err_addr, 32'h3000_0040);
    m0_valid = 0;
    tick();

    // ---- s_ready glitch while IDLE ----
    s_ready = 1; s_rdata = 32'h7777_7777;
    tick();
    chk("gl_s_valid", s_valid, 0);
    chk("gl_m0_ready", m0_ready, 0);
    chk("gl_m1_ready", m1_ready, 0);
    tick();
    s_ready = 0;
    chk("gl_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("gl_m1_rdata", m1_rdata, 32'hCAFE_0001);

    // ---- reset during BUSY ----
    m0_valid = 1; m0_addr = 32'h4000_0000;
    tick();
    chk("rb_s_valid_busy", s_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rb_s_valid", s_valid, 0);
    chk("rb_s_addr", s_addr, 0);
    chk("rb_m0_rdata", m0_rdata, 0);
    chk("rb_err_flag", err_flag, 0);
    s_ready = 1;
    tick();
    chk("rb_m0_ready", m0_ready, 0);
    resetn = 1'b1;
    // first tie after reset goes to m0
    m1_valid = 1; m1_addr = 32'h5000_0000;
    s_rdata = 32'h0BAD_F00D;
    tick();
    chk("rb_tie_owner", s_owner, 0);
    chk("rb_tie_addr", s_addr, 32'h4000_0000);
    tick();
    chk("rb_tie_m0_ready", m0_ready, 1);
    chk("rb_tie_m1_ready", m1_ready, 0);
    m0_valid = 0; m1_valid = 0; s_ready = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
